// File: rtl/qpp_interleaver_core_pkg.sv
// Shared definitions for the QPP interleaver address generator: data width,
// FSM state encoding and a few LTE (K, f1, f2) reference triples.
package qpp_interleaver_core_pkg;

   // Width of K / f1 / f2 / index data (K up to 6144 needs 13 bits).
   localparam int unsigned QPP_KW = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } qpp_state_e;

   typedef struct packed {
      logic [15:0] k;
      logic [15:0] f1;
      logic [15:0] f2;
   } qpp_triple_t;

   // LTE table entries used for bring-up: K=48, K=1008, K=6144.
   localparam qpp_triple_t [0:2] QPP_LTE_TRIPLES = {
      {16'd48,   16'd7,   16'd12},
      {16'd1008, 16'd55,  16'd84},
      {16'd6144, 16'd263, 16'd480}
   };

endpackage

// File: rtl/qpp_interleaver_core_if.sv
// Signal bundle for driving and observing qpp_interleaver_core.
interface dut_if
   import qpp_interleaver_core_pkg::*;
#(
   parameter int unsigned KW = QPP_KW
) (
   input logic aclk,
   input logic aresetn
);
   logic [KW-1:0] k_tdata;
   logic [KW-1:0] f1_tdata;
   logic [KW-1:0] f2_tdata;
   logic          k_tvalid;
   logic          k_tready;
   logic [KW-1:0] ind_tdata;
   logic          ind_tvalid;
   logic          ind_tready;
   logic          ind_tlast;
   logic          ind_tuser;
endinterface

// File: rtl/qpp_mod_add.sv
// (a + b) mod m for a, b < m: one add, one conditional subtract.
module qpp_mod_add
   import qpp_interleaver_core_pkg::*;
#(
   parameter int unsigned KW = QPP_KW
) (
   input  logic [KW-1:0] a,
   input  logic [KW-1:0] b,
   input  logic [KW-1:0] m,
   output logic [KW-1:0] y
);
   logic [KW:0]   sum;
   logic [KW-1:0] diff;

   // Low KW bits of (sum - m) equal sum[KW-1:0] - m modulo 2^KW, so the
   // subtract only needs KW bits; the carry bit still feeds the compare.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = sum[KW-1:0] - m;
      y    = (sum >= {1'b0, m}) ? diff : sum[KW-1:0];
   end

endmodule

// File: rtl/qpp_interleaver_core.sv
// LTE turbo QPP interleaver address generator. Accepts a (K, f1, f2)
// descriptor and streams pi(i) = (f1*i + f2*i^2) mod K for i = 0..K-1 using
// an add-only recurrence. Reset input is active-high despite its name.
module qpp_interleaver_core
   import qpp_interleaver_core_pkg::*;
#(
   parameter int unsigned KW = QPP_KW
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [KW-1:0] s_axis_k_tdata,
   input  logic [KW-1:0] s_axis_f1_tdata,
   input  logic [KW-1:0] s_axis_f2_tdata,
   input  logic          s_axis_k_tvalid,
   output logic          s_axis_k_tready,
   output logic [KW-1:0] m_axis_ind_tdata,
   output logic          m_axis_ind_tvalid,
   input  logic          m_axis_ind_tready,
   output logic          m_axis_ind_tlast,
   output logic          m_axis_ind_tuser
);
   localparam logic [KW-1:0] ONE = KW'(1);

   qpp_state_e    state_q, state_d;
   logic          rdy_q, rdy_d;
   logic          vld_q, vld_d;
   logic          last_q, last_d;
   logic          user_q, user_d;
   logic [KW-1:0] data_q, data_d;     // current pi(i)
   logic [KW-1:0] g_q, g_d;           // current g(i)
   logic [KW-1:0] f2x2_q, f2x2_d;     // 2*f2 mod K
   logic [KW-1:0] k_q, k_d;
   logic [KW-1:0] cnt_q, cnt_d;       // current i

   logic [KW-1:0] pi_a, pi_b, g_a, g_b, mod_k;
   logic [KW-1:0] pi_sum, g_sum;

   // The two adders are shared: in IDLE they form g(0) and 2*f2 from the
   // incoming descriptor, in RUN they step pi and g.
   always_comb begin
      if (state_q == ST_IDLE) begin
         pi_a  = s_axis_f1_tdata;
         pi_b  = s_axis_f2_tdata;
         g_a   = s_axis_f2_tdata;
         g_b   = s_axis_f2_tdata;
         mod_k = s_axis_k_tdata;
      end else begin
         pi_a  = data_q;
         pi_b  = g_q;
         g_a   = g_q;
         g_b   = f2x2_q;
         mod_k = k_q;
      end
   end

   qpp_mod_add #(.KW(KW)) u_mod_pi (
      .a (pi_a),
      .b (pi_b),
      .m (mod_k),
      .y (pi_sum)
   );

   qpp_mod_add #(.KW(KW)) u_mod_g (
      .a (g_a),
      .b (g_b),
      .m (mod_k),
      .y (g_sum)
   );

   // Next-state, descriptor latch and index-stream update.
   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      vld_d   = vld_q;
      last_d  = last_q;
      user_d  = user_q;
      data_d  = data_q;
      g_d     = g_q;
      f2x2_d  = f2x2_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            rdy_d = 1'b1;
            // A K=0 descriptor is consumed but starts nothing.
            if (rdy_q && s_axis_k_tvalid && (s_axis_k_tdata != '0)) begin
               k_d     = s_axis_k_tdata;
               g_d     = pi_sum;
               f2x2_d  = g_sum;
               cnt_d   = '0;
               data_d  = '0;
               vld_d   = 1'b1;
               user_d  = 1'b1;
               last_d  = (s_axis_k_tdata == ONE);
               rdy_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            rdy_d = 1'b0;
            if (vld_q && m_axis_ind_tready) begin
               if (last_q) begin
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
                  user_d  = 1'b0;
                  data_d  = '0;
                  rdy_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  data_d = pi_sum;
                  g_d    = g_sum;
                  cnt_d  = cnt_q + ONE;
                  user_d = 1'b0;
                  last_d = ((cnt_q + ONE) == (k_q - ONE));
               end
            end
         end
      endcase
   end

   // State and output registers; reset abandons any block in flight.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
         data_q  <= '0;
         g_q     <= '0;
         f2x2_q  <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         user_q  <= user_d;
         data_q  <= data_d;
         g_q     <= g_d;
         f2x2_q  <= f2x2_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_axis_k_tready   = rdy_q;
   assign m_axis_ind_tvalid = vld_q;
   assign m_axis_ind_tdata  = data_q;
   assign m_axis_ind_tlast  = last_q;
   assign m_axis_ind_tuser  = user_q;

endmodule

// File: tb/tb_qpp_interleaver_core.sv
// Directed bench for qpp_interleaver_core: LTE block sizes, K=0/K=1,
// downstream stalls, back-to-back descriptors and reset mid-block.
module tb_qpp_interleaver_core;
   import qpp_interleaver_core_pkg::*;

   logic aclk = 1'b0;
   logic aresetn;
   int unsigned total = 0;
   int unsigned bad = 0;
   logic [15:0] cap [0:6143];
   logic [15:0] ref1008 [0:1007];
   bit          seen [0:6143];

   always #5 aclk = ~aclk;

   dut_if #(.KW(QPP_KW)) dif (.aclk(aclk), .aresetn(aresetn));

   qpp_interleaver_core #(.KW(QPP_KW)) dut (
      .aclk              (dif.aclk),
      .aresetn           (dif.aresetn),
      .s_axis_k_tdata    (dif.k_tdata),
      .s_axis_f1_tdata   (dif.f1_tdata),
      .s_axis_f2_tdata   (dif.f2_tdata),
      .s_axis_k_tvalid   (dif.k_tvalid),
      .s_axis_k_tready   (dif.k_tready),
      .m_axis_ind_tdata  (dif.ind_tdata),
      .m_axis_ind_tvalid (dif.ind_tvalid),
      .m_axis_ind_tready (dif.ind_tready),
      .m_axis_ind_tlast  (dif.ind_tlast),
      .m_axis_ind_tuser  (dif.ind_tuser)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Closed-form reference, independent of the hardware recurrence.
   function automatic logic [31:0] qpp_ref(input int unsigned k, f1, f2, i);
      longint unsigned v;
      v = (longint'(f1) * longint'(i) + longint'(f2) * longint'(i) * longint'(i)) % longint'(k);
      return 32'(v);
   endfunction

   task automatic send_desc(input string pfx, input int unsigned k, f1, f2);
      int unsigned n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      @(posedge aclk); #1;
      dif.k_tdata  = 16'(k);
      dif.f1_tdata = 16'(f1);
      dif.f2_tdata = 16'(f2);
      dif.k_tvalid = 1'b1;
      while (!ok && n < 20000) begin
         @(negedge aclk);
         n++;
         if (dif.k_tready === 1'b1) ok = 1'b1;
      end
      @(posedge aclk); #1;
      dif.k_tvalid = 1'b0;
      chk({pfx, "_accept"}, 32'(ok), 32'd1);
   endtask

   task automatic run_block(input string pfx, input int unsigned k, f1, f2,
                            input bit stall, input int unsigned stop_at,
                            output int unsigned nbeats);
      int unsigned budget;
      bit          held;
      logic [15:0] hd;
      logic        hu, hl;
      budget = 0;
      held   = 1'b0;
      hd     = '0;
      hu     = 1'b0;
      hl     = 1'b0;
      nbeats = 0;
      dif.ind_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      while (nbeats < stop_at && budget < 4 * stop_at + 50) begin
         @(negedge aclk);
         budget++;
         if (held) begin
            chk({pfx, "_hold_valid"}, 32'(dif.ind_tvalid), 32'd1);
            chk({pfx, "_hold_data"}, 32'(dif.ind_tdata), 32'(hd));
            chk({pfx, "_hold_user"}, 32'(dif.ind_tuser), 32'(hu));
            chk({pfx, "_hold_last"}, 32'(dif.ind_tlast), 32'(hl));
         end
         held = 1'b0;
         if (dif.ind_tvalid === 1'b1) begin
            chk({pfx, "_k_tready_busy"}, 32'(dif.k_tready), 32'd0);
            if (dif.ind_tready) begin
               cap[nbeats] = dif.ind_tdata;
               chk({pfx, "_data"}, 32'(dif.ind_tdata), qpp_ref(k, f1, f2, nbeats));
               chk({pfx, "_tuser"}, 32'(dif.ind_tuser), 32'(nbeats == 0));
               chk({pfx, "_tlast"}, 32'(dif.ind_tlast), 32'(nbeats == k - 1));
               nbeats++;
            end else begin
               held = 1'b1;
               hd   = dif.ind_tdata;
               hu   = dif.ind_tuser;
               hl   = dif.ind_tlast;
            end
         end
         @(posedge aclk); #1;
         dif.ind_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      dif.ind_tready = 1'b1;
      chk({pfx, "_beats"}, nbeats, stop_at);
   endtask

   task automatic check_idle(input string pfx);
      @(negedge aclk);
      chk({pfx, "_idle_tvalid"}, 32'(dif.ind_tvalid), 32'd0);
      chk({pfx, "_idle_k_tready"}, 32'(dif.k_tready), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned nb;
      int unsigned dup, missing, diffs;

      aresetn        = 1'b1;
      dif.k_tdata    = '0;
      dif.f1_tdata   = '0;
      dif.f2_tdata   = '0;
      dif.k_tvalid   = 1'b0;
      dif.ind_tready = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_k_tready", 32'(dif.k_tready), 32'd0);
      chk("rst_tvalid", 32'(dif.ind_tvalid), 32'd0);
      chk("rst_tdata", 32'(dif.ind_tdata), 32'd0);
      chk("rst_tlast", 32'(dif.ind_tlast), 32'd0);
      chk("rst_tuser", 32'(dif.ind_tuser), 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      chk("post_rst_k_tready", 32'(dif.k_tready), 32'd1);

      // K=48 LTE entry.
      send_desc("k48", QPP_LTE_TRIPLES[0].k, QPP_LTE_TRIPLES[0].f1, QPP_LTE_TRIPLES[0].f2);
      run_block("k48", 48, 7, 12, 1'b0, 48, nb);
      chk("k48_pi0", 32'(cap[0]), 32'd0);
      chk("k48_pi1", 32'(cap[1]), 32'd19);
      chk("k48_pi2", 32'(cap[2]), 32'd14);
      chk("k48_pi3", 32'(cap[3]), 32'd33);
      chk("k48_pi47", 32'(cap[47]), 32'd5);
      check_idle("k48");

      // K=0: consumed, nothing emitted.
      send_desc("k0", 0, 0, 0);
      repeat (3) begin
         @(negedge aclk);
         chk("k0_no_beat", 32'(dif.ind_tvalid), 32'd0);
      end
      chk("k0_k_tready", 32'(dif.k_tready), 32'd1);

      // K=1: single beat with tuser and tlast together.
      send_desc("k1", 1, 0, 0);
      run_block("k1", 1, 0, 0, 1'b0, 1, nb);
      chk("k1_pi0", 32'(cap[0]), 32'd0);
      check_idle("k1");

      // K=1008 without stalls.
      send_desc("k1008", 1008, 55, 84);
      run_block("k1008", 1008, 55, 84, 1'b0, 1008, nb);
      chk("k1008_pi1", 32'(cap[1]), 32'd139);
      chk("k1008_pi2", 32'(cap[2]), 32'd446);
      chk("k1008_pi1007", 32'(cap[1007]), 32'd29);
      for (int i = 0; i < 1008; i++) ref1008[i] = cap[i];
      check_idle("k1008");

      // K=1008 with random downstream backpressure.
      send_desc("k1008s", 1008, 55, 84);
      run_block("k1008s", 1008, 55, 84, 1'b1, 1008, nb);
      diffs = 0;
      for (int i = 0; i < 1008; i++) if (cap[i] !== ref1008[i]) diffs++;
      chk("k1008s_vs_nostall", diffs, 32'd0);
      check_idle("k1008s");

      // Back-to-back: 1008 descriptor held valid while the 48 block runs.
      send_desc("b2b48", 48, 7, 12);
      dif.k_tdata  = 16'd1008;
      dif.f1_tdata = 16'd55;
      dif.f2_tdata = 16'd84;
      dif.k_tvalid = 1'b1;
      run_block("b2b48", 48, 7, 12, 1'b0, 48, nb);
      @(negedge aclk);
      chk("b2b_k_tready_back", 32'(dif.k_tready), 32'd1);
      chk("b2b_gap_tvalid", 32'(dif.ind_tvalid), 32'd0);
      @(posedge aclk); #1;
      dif.k_tvalid = 1'b0;
      run_block("b2b1008", 1008, 55, 84, 1'b0, 1008, nb);
      chk("b2b1008_pi0", 32'(cap[0]), 32'd0);
      chk("b2b1008_pi1007", 32'(cap[1007]), 32'd29);
      check_idle("b2b1008");

      // K=6144: full permutation.
      send_desc("k6144", 6144, 263, 480);
      run_block("k6144", 6144, 263, 480, 1'b0, 6144, nb);
      chk("k6144_pi1", 32'(cap[1]), 32'd743);
      chk("k6144_pi6143", 32'(cap[6143]), 32'd217);
      dup = 0;
      missing = 0;
      for (int i = 0; i < 6144; i++) seen[i] = 1'b0;
      for (int i = 0; i < 6144; i++) begin
         if (cap[i] >= 16'd6144) missing++;
         else if (seen[cap[i]]) dup++;
         else seen[cap[i]] = 1'b1;
      end
      for (int i = 0; i < 6144; i++) if (!seen[i]) missing++;
      chk("k6144_perm_dup", dup, 32'd0);
      chk("k6144_perm_missing", missing, 32'd0);
      check_idle("k6144");

      // Reset at beat 20 of a K=6144 block, then a fresh K=48 block.
      send_desc("rstmid", 6144, 263, 480);
      run_block("rstmid", 6144, 263, 480, 1'b0, 20, nb);
      aresetn = 1'b1;
      #1;
      chk("rstmid_tvalid", 32'(dif.ind_tvalid), 32'd0);
      chk("rstmid_tdata", 32'(dif.ind_tdata), 32'd0);
      chk("rstmid_tuser", 32'(dif.ind_tuser), 32'd0);
      chk("rstmid_tlast", 32'(dif.ind_tlast), 32'd0);
      chk("rstmid_k_tready", 32'(dif.k_tready), 32'd0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      send_desc("after_rst", 48, 7, 12);
      run_block("after_rst", 48, 7, 12, 1'b0, 48, nb);
      chk("after_rst_pi3", 32'(cap[3]), 32'd33);
      chk("after_rst_pi47", 32'(cap[47]), 32'd5);
      check_idle("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
